// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: load-use stalls,
// taken-branch flushes, multi-cycle multiply sequencing and perf counters.
module hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_mul,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mul_start,
    output logic        mul_done,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MUL_LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] stall_cnt_reg, flush_cnt_reg;
    logic        lu;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mul_start   = 1'b0;
        mul_done    = 1'b0;
        state_next  = state_reg;
        cnt_next    = cnt_reg;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_next  = RUN;
            cnt_next    = 4'd0;
        end else if (ex_branch_taken) begin
            // Squash wins over everything, including an in-flight multiply.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = RUN;
            cnt_next    = 4'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (lu) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_is_mul) begin
                        mul_start   = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_next  = MUL_WAIT;
                        cnt_next    = WAIT_INIT;
                    end
                end
                MUL_WAIT: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_next    = cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        state_next = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    // The multiply still sits in ID this cycle; do not restart it.
                    mul_done   = 1'b1;
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            cnt_reg       <= 4'd0;
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (!pc_write && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (ifid_flush && (flush_cnt_reg != 16'hFFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign state     = state_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_LAT=4).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_is_mul, ex_memread, ex_branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, mul_start, mul_done;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mul_start(mul_start), .mul_done(mul_done),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_is_mul = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    endtask

    // Advance one edge; inputs change 1 time unit after it, outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write actual=%0b expected=0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL rst_ifid_write actual=%0b expected=0", ifid_write); end
        checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble actual=%0b expected=1", idex_bubble); end
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state actual=%0d expected=0", state); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt actual=%0d expected=0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt actual=%0d expected=0", flush_cnt); end
        checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble, mul_start, mul_done} !== 6'b110000) begin
            errors++; $display("FAIL rst_release_outputs actual=%b expected=110000",
                {pc_write, ifid_write, ifid_flush, idex_bubble, mul_start, mul_done}); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
            errors++; $display("FAIL lu_stall actual=%b expected=001", {pc_write, ifid_write, idex_bubble}); end
        step();
        idle();
        #1;
        checks++; if ({pc_write, idex_bubble} !== 2'b10) begin
            errors++; $display("FAIL lu_release actual=%b expected=10", {pc_write, idex_bubble}); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt actual=%0d expected=1", stall_cnt); end
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_r0 actual=%0b expected=1", pc_write); end
        step();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_r0_cnt actual=%0d expected=1", stall_cnt); end
        idle();
    endtask

    task automatic test_rt_match();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rt_unused actual=%0b expected=1", pc_write); end
        id_uses_rt = 1'b1;
        #1;
        checks++; if ({pc_write, idex_bubble} !== 2'b01) begin
            errors++; $display("FAIL rt_used actual=%b expected=01", {pc_write, idex_bubble}); end
        step();
        idle();
        #1;
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL rt_stall_cnt actual=%0d expected=1", stall_cnt); end
    endtask

    task automatic test_multiply();
        do_reset();
        id_is_mul = 1'b1;
        #1;
        checks++; if ({mul_start, pc_write, ifid_write, idex_bubble} !== 4'b1001) begin
            errors++; $display("FAIL mul_t0 actual=%b expected=1001", {mul_start, pc_write, ifid_write, idex_bubble}); end
        for (int t = 1; t <= 3; t++) begin
            step();
            checks++; if ({state, mul_start, mul_done, pc_write} !== 5'b01000) begin
                errors++; $display("FAIL mul_wait_t%0d actual=%b expected=01000", t, {state, mul_start, mul_done, pc_write}); end
        end
        step();
        checks++; if ({state, mul_start, mul_done, pc_write, idex_bubble} !== 6'b100110) begin
            errors++; $display("FAIL mul_t4 actual=%b expected=100110", {state, mul_start, mul_done, pc_write, idex_bubble}); end
        step();
        id_is_mul = 1'b0;
        #1;
        checks++; if ({state, mul_start, mul_done} !== 4'b0000) begin
            errors++; $display("FAIL mul_t5 actual=%b expected=0000", {state, mul_start, mul_done}); end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL mul_stall_cnt actual=%0d expected=4", stall_cnt); end
    endtask

    task automatic test_branch_mul();
        do_reset();
        id_is_mul = 1'b1;
        step();
        step();
        ex_branch_taken = 1'b1;
        #1;
        checks++; if ({ifid_flush, idex_bubble, pc_write, ifid_write, mul_done} !== 5'b11110) begin
            errors++; $display("FAIL br_mul_t2 actual=%b expected=11110", {ifid_flush, idex_bubble, pc_write, ifid_write, mul_done}); end
        step();
        idle();
        #1;
        checks++; if ({state, mul_done} !== 3'b000) begin
            errors++; $display("FAIL br_mul_t3 actual=%b expected=000", {state, mul_done}); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt actual=%0d expected=1", flush_cnt); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL br_stall_cnt actual=%0d expected=2", stall_cnt); end
        step();
        step();
        checks++; if ({state, mul_done} !== 3'b000) begin
            errors++; $display("FAIL br_no_done actual=%b expected=000", {state, mul_done}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_is_mul = 1'b1;
        #1;
        checks++; if ({pc_write, idex_bubble, mul_start} !== 3'b010) begin
            errors++; $display("FAIL lu_mul_stall actual=%b expected=010", {pc_write, idex_bubble, mul_start}); end
        step();
        ex_memread = 1'b0;
        #1;
        checks++; if ({state, mul_start} !== 3'b001) begin
            errors++; $display("FAIL lu_mul_start actual=%b expected=001", {state, mul_start}); end
        step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL lu_mul_wait actual=%0d expected=1", state); end
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; ex_branch_taken = 1'b1;
        #1;
        checks++; if ({ifid_flush, pc_write, idex_bubble} !== 3'b111) begin
            errors++; $display("FAIL br_lu actual=%b expected=111", {ifid_flush, pc_write, idex_bubble}); end
        step();
        idle();
        #1;
        checks++; if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0}) begin
            errors++; $display("FAIL br_lu_cnts actual=%0d/%0d expected=1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        ex_branch_taken = 1'b1;
        step();
        ex_branch_taken = 1'b0;
        id_is_mul = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        checks++; if ({pc_write, ifid_write, idex_bubble, mul_start, mul_done} !== 5'b00100) begin
            errors++; $display("FAIL rmm_outputs actual=%b expected=00100", {pc_write, ifid_write, idex_bubble, mul_start, mul_done}); end
        step();
        reset = 1'b0;
        id_is_mul = 1'b0;
        #1;
        checks++; if ({state, mul_done} !== 3'b000) begin
            errors++; $display("FAIL rmm_state actual=%b expected=000", {state, mul_done}); end
        checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin
            errors++; $display("FAIL rmm_cnts actual=%0d/%0d expected=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre actual=%h expected=fffe", stall_cnt); end
        step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_top actual=%h expected=ffff", stall_cnt); end
        step();
        step();
        step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold actual=%h expected=ffff", stall_cnt); end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_rt_match();
        test_multiply();
        test_branch_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
